display_source_mux: RTL and testbench

//  N-source seven-segment display selector + scanner; next generation of the two-way mode mux.

---
 rtl/display_pkg.sv | 33 +++
 rtl/seg_scan_timer.sv | 45 ++++
 rtl/display_source_mux.sv | 127 ++++++++++++
 tb/tb_display_source_mux.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared seven-segment types and the hex-to-segment decoder
// used by display_source_mux and its scan timer.
package display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  function automatic seg_t hex_to_seg(input logic [3:0] hex);
    seg_t s;
    case (hex)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan timer: tick every CLK_HZ/SCAN_HZ clocks, digit index,
// and a frame_wrap strobe on the tick that returns the index to 0.
module seg_scan_timer #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int N_DIGITS = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  output logic                        o_tick,
  output logic [$clog2(N_DIGITS)-1:0] o_digit_idx,
  output logic                        o_frame_wrap
);

  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(N_DIGITS);

  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic          w_tick;
  logic          w_wrap;

  assign w_tick = (r_cnt == CW'(TICK_DIV - 1));
  assign w_wrap = w_tick && (r_idx == IW'(N_DIGITS - 1));

  // free-running tick divider and digit index
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_wrap)
        r_idx <= '0;
      else if (w_tick)
        r_idx <= r_idx + 1'b1;
    end
  end

  assign o_tick       = w_tick;
  assign o_digit_idx  = r_idx;
  assign o_frame_wrap = w_wrap;

endmodule

// File: rtl/display_source_mux.sv
// N-source seven-segment selector/scanner; source changes on frame wrap.
// Optional SWITCH_BLANK_EN inserts one dark frame before a new source.
module display_source_mux
  import display_pkg::*;
#(
  parameter int N_SRC    = 4,
  parameter int N_DIGITS = 8,
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000
) (
  input  logic                        clk_100MHz,
  input  logic                        reset,
  input  logic                        mode_next,
  input  logic [N_SRC*N_DIGITS*4-1:0] src_digits,
  input  logic [N_SRC*N_DIGITS-1:0]   src_dp,
  input  logic [N_SRC*N_DIGITS-1:0]   src_blank,
  output logic [6:0]                  segs_1,
  output logic [N_DIGITS-1:0]         an,
  output logic                        point,
  output logic [$clog2(N_SRC)-1:0]    sel_src,
  output logic                        switching
);

  localparam int SW = $clog2(N_SRC);
  localparam int IW = $clog2(N_DIGITS);
  localparam int PW = $clog2(N_SRC * N_DIGITS);

  logic [SW-1:0]       r_tgt;
  logic [SW-1:0]       r_sel;
  logic [N_DIGITS-1:0] r_an;
  seg_t                r_segs;
  logic                r_point;

  logic                w_tick;
  logic                w_wrap;
  logic [IW-1:0]       w_digit_idx;
  logic [IW-1:0]       w_new_idx;
  logic [SW-1:0]       w_sel_next;
  logic [SW-1:0]       w_tgt_inc;
  logic [PW-1:0]       w_pos;
  logic [3:0]          w_hex;
  logic                w_dp;
  logic                w_blk;
  logic                w_blank_next;
  logic                w_blank_active;

  seg_scan_timer #(
    .CLK_HZ   (CLK_HZ),
    .SCAN_HZ  (SCAN_HZ),
    .N_DIGITS (N_DIGITS)
  ) u_timer (
    .i_clk        (clk_100MHz),
    .i_rst_n      (reset),
    .o_tick       (w_tick),
    .o_digit_idx  (w_digit_idx),
    .o_frame_wrap (w_wrap)
  );

  assign w_tgt_inc = (r_tgt == SW'(N_SRC - 1)) ? '0 : r_tgt + 1'b1;

`ifdef SWITCH_BLANK_EN
  logic r_blank;

  // a wrap that changes source starts a dark frame; a wrap without one ends it
  always_ff @(posedge clk_100MHz) begin
    if (!reset)
      r_blank <= 1'b0;
    else if (w_wrap)
      r_blank <= w_blank_next;
  end

  assign w_blank_active = r_blank;
  assign w_blank_next   = w_wrap ? (r_tgt != r_sel) : r_blank;
`else
  assign w_blank_active = 1'b0;
  assign w_blank_next   = 1'b0;
`endif

  // next digit slot, next source, and the live source data for that slot
  always_comb begin
    w_new_idx  = w_wrap ? '0 : w_digit_idx + 1'b1;
    w_sel_next = w_wrap ? r_tgt : r_sel;
    w_pos      = PW'(w_sel_next) * PW'(N_DIGITS) + PW'(w_new_idx);
    w_hex      = src_digits[{w_pos, 2'b00} +: 4];
    w_dp       = src_dp[w_pos];
    w_blk      = src_blank[w_pos];
  end

  // target follows every mode_next pulse; selection only moves on frame wrap
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      r_tgt <= '0;
      r_sel <= '0;
    end else begin
      if (w_wrap)
        r_sel <= r_tgt;
      if (mode_next)
        r_tgt <= w_tgt_inc;
    end
  end

  // pin registers refresh only on scan ticks
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      r_an    <= '1;
      r_segs  <= SEG_OFF;
      r_point <= 1'b1;
    end else if (w_tick) begin
      if (w_blank_next) begin
        r_an    <= '1;
        r_segs  <= SEG_OFF;
        r_point <= 1'b1;
      end else begin
        r_an    <= ~(N_DIGITS'(1) << w_new_idx);
        r_segs  <= w_blk ? SEG_OFF : hex_to_seg(w_hex);
        r_point <= w_blk | ~w_dp;
      end
    end
  end

  assign an        = r_an;
  assign segs_1    = r_segs;
  assign point     = r_point;
  assign sel_src   = r_sel;
  assign switching = (r_tgt != r_sel) | w_blank_active;

endmodule

// File: tb/tb_display_source_mux.sv
// Directed bench for display_source_mux with a cycle scoreboard.
// Build with or without SWITCH_BLANK_EN.
module tb_display_source_mux;

  localparam int N_SRC    = 4;
  localparam int N_DIG    = 8;
  localparam int TICK_DIV = 10;

  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] segs;
    logic       point;
    logic [1:0] sel;
    logic       sw;
  } obs_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         mode_next = 1'b0;
  logic [127:0] src_digits;
  logic [31:0]  src_dp;
  logic [31:0]  src_blank;
  logic [6:0]   segs_1;
  logic [7:0]   an;
  logic         point;
  logic [1:0]   sel_src;
  logic         switching;

  int checks = 0;
  int failures = 0;
  obs_t sb_q[$];

  int   m_cnt, m_idx, m_sel, m_tgt;
  bit   m_blank, m_ticked;
  logic [7:0] m_an;
  logic [6:0] m_seg;
  logic       m_pt;

  display_source_mux #(
    .N_SRC    (N_SRC),
    .N_DIGITS (N_DIG),
    .CLK_HZ   (1000),
    .SCAN_HZ  (100)
  ) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .mode_next  (mode_next),
    .src_digits (src_digits),
    .src_dp     (src_dp),
    .src_blank  (src_blank),
    .segs_1     (segs_1),
    .an         (an),
    .point      (point),
    .sel_src    (sel_src),
    .switching  (switching)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_step();
    int p;
    if (!reset) begin
      m_cnt = 0; m_idx = 0; m_sel = 0; m_tgt = 0;
      m_blank = 0; m_ticked = 0;
      m_an = 8'hFF; m_seg = 7'h7F; m_pt = 1'b1;
    end else begin
      m_ticked = (m_cnt == TICK_DIV - 1);
      m_cnt = m_ticked ? 0 : m_cnt + 1;
      if (m_ticked) begin
        if (m_idx == N_DIG - 1) begin
          m_idx = 0;
`ifdef SWITCH_BLANK_EN
          m_blank = (m_tgt != m_sel);
`endif
          m_sel = m_tgt;
        end else begin
          m_idx++;
        end
        if (m_blank) begin
          m_an = 8'hFF; m_seg = 7'h7F; m_pt = 1'b1;
        end else begin
          p = m_sel * N_DIG + m_idx;
          m_an = 8'hFF;
          m_an[m_idx] = 1'b0;
          m_seg = src_blank[p] ? 7'h7F : SEG[src_digits[p*4 +: 4]];
          m_pt = src_blank[p] | ~src_dp[p];
        end
      end
      if (mode_next) m_tgt = (m_tgt + 1) % N_SRC;
    end
  endtask

  task automatic cycle();
    obs_t e, got;
    model_step();
    e.an = m_an; e.segs = m_seg; e.point = m_pt;
    e.sel = 2'(m_sel);
    e.sw = (m_tgt != m_sel) || m_blank;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = {an, segs_1, point, sel_src, switching};
    e = sb_q.pop_front();
    check("sb", 32'(got), 32'(e));
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to_idx(input int k);
    bit hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      cycle();
      if (m_ticked && m_idx == k) hit = 1;
    end
    checks++;
    assert (hit) else begin
      failures++;
      $error("FAIL run_to_idx%0d observed=timeout expected=reached", k);
    end
  endtask

  task automatic pulse();
    mode_next = 1'b1;
    cycle();
    mode_next = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_an"}, 32'(an), 32'h0FF);
    check({tag, "_segs"}, 32'(segs_1), 32'h7F);
    check({tag, "_point"}, 32'(point), 32'h1);
    check({tag, "_sel"}, 32'(sel_src), 32'h0);
    check({tag, "_sw"}, 32'(switching), 32'h0);
  endtask

  initial begin
    src_dp = '0;
    src_blank = '0;
    for (int s = 0; s < N_SRC; s++)
      for (int d = 0; d < N_DIG; d++)
        case (s)
          0: src_digits[(s*N_DIG+d)*4 +: 4] = 4'(d);
          1: src_digits[(s*N_DIG+d)*4 +: 4] = 4'(d + 8);
          2: src_digits[(s*N_DIG+d)*4 +: 4] = 4'(d * 3);
          default: src_digits[(s*N_DIG+d)*4 +: 4] = 4'(15 - d);
        endcase
    src_blank[2*N_DIG+5] = 1'b1;
    src_dp[2*N_DIG+2] = 1'b1;

    @(negedge clk);
    run(3);
    check_idle("reset");

    reset = 1'b1;
    run_to_idx(7);
    check("d7_an", 32'(an), 32'h07F);
    check("d7_segs", 32'(segs_1), 32'h78);
    run_to_idx(0);
    check("d0_an", 32'(an), 32'h0FE);
    check("d0_segs", 32'(segs_1), 32'h40);

    run_to_idx(3);
    pulse();
    check("sw_pending", 32'(switching), 32'h1);
    check("sel_hold", 32'(sel_src), 32'h0);
    run_to_idx(7);
    check("sel_prewrap", 32'(sel_src), 32'h0);
    run_to_idx(0);
    check("sel_wrap", 32'(sel_src), 32'h1);
`ifdef SWITCH_BLANK_EN
    check("blank_first", 32'(an), 32'h0FF);
    check("blank_sw", 32'(switching), 32'h1);
    run(TICK_DIV * N_DIG - 1);
    check("blank_last", 32'(an), 32'h0FF);
    run(1);
`endif
    check("src1_d0_an", 32'(an), 32'h0FE);
    check("src1_d0_segs", 32'(segs_1), 32'h00);
    check("sw_done", 32'(switching), 32'h0);

    run_to_idx(2);
    pulse();
    check("net_sw1", 32'(switching), 32'h1);
    run(2);
    pulse();
    pulse();
    run(1);
    pulse();
    check("net_sw0", 32'(switching), 32'h0);
    run_to_idx(0);
    check("net_sel", 32'(sel_src), 32'h1);

    pulse();
    run_to_idx(0);
    check("sel2", 32'(sel_src), 32'h2);
`ifdef SWITCH_BLANK_EN
    check("blank2_an", 32'(an), 32'h0FF);
    run_to_idx(0);
`endif
    run_to_idx(2);
    check("dp_an", 32'(an), 32'h0FB);
    check("dp_point", 32'(point), 32'h0);
    check("dp_segs", 32'(segs_1), 32'h02);
    run_to_idx(5);
    check("blk_an", 32'(an), 32'h0DF);
    check("blk_segs", 32'(segs_1), 32'h7F);
    check("blk_point", 32'(point), 32'h1);

    run_to_idx(3);
    pulse();
    check("mid_sw", 32'(switching), 32'h1);
    reset = 1'b0;
    cycle();
    check_idle("midrst");
    reset = 1'b1;
    run(TICK_DIV * 3);
    check("post_rst_an", 32'(an), 32'h0F7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
